// File: rtl/stap_visa_shift_reg.sv
// stap_visa_shift_reg: capture/shift front end of the sTAP VISA override data register.
module stap_visa_shift_reg #(
    parameter int VISA_SHIFT_STAP_WIDTH = 8,
    parameter logic [VISA_SHIFT_STAP_WIDTH-1:0] VISA_SHIFT_STAP_RESET_VALUE = '0,
    localparam int W = VISA_SHIFT_STAP_WIDTH,
    localparam int CNT_W = $clog2(W + 2)
) (
    input  logic             ftap_tck,
    input  logic             powergoodrst_b,
    input  logic             stap_fsm_tlrs,
    input  logic             selected_visa_reg,
    input  logic             stap_fsm_capture_dr,
    input  logic             stap_fsm_shift_dr,
    input  logic             stap_fsm_update_dr,
    input  logic             ftap_tdi,
    input  logic [W-1:0]     visa_capture_data,
    output logic [W-1:0]     visa_shift_register,
    output logic             visa_tdo,
    output logic [CNT_W-1:0] visa_shift_count,
    output logic             visa_len_err,
    output logic             visa_update_valid
);
    typedef enum logic [1:0] {IDLE, CAPT, SHIFT} state_t;
    state_t state;
    logic [W-1:0] shifted;
    logic [CNT_W-1:0] count_inc;
    logic count_ok;
    // loop form keeps the W==1 case free of a reversed slice
    always_comb begin
        shifted = {W{ftap_tdi}};
        for (int i = 0; i < W - 1; i++) shifted[i] = visa_shift_register[i+1];
    end
    assign count_inc = (visa_shift_count == CNT_W'(W + 1)) ? visa_shift_count : visa_shift_count + CNT_W'(1);
    assign count_ok = (visa_shift_count == CNT_W'(W));
    assign visa_tdo = visa_shift_register[0];
    always_ff @(posedge ftap_tck) begin
        if (!powergoodrst_b || stap_fsm_tlrs) begin
            state               <= IDLE;
            visa_shift_register <= VISA_SHIFT_STAP_RESET_VALUE;
            visa_shift_count    <= '0;
            visa_len_err        <= 1'b0;
            visa_update_valid   <= 1'b0;
        end else begin
            visa_update_valid <= 1'b0;
            if (!selected_visa_reg) begin
                state <= IDLE;
            end else if (stap_fsm_capture_dr) begin
                state               <= CAPT;
                visa_shift_register <= visa_capture_data;
                visa_shift_count    <= '0;
                visa_len_err        <= 1'b0;
            end else if (stap_fsm_shift_dr) begin
                visa_shift_register <= shifted;
                visa_shift_count    <= count_inc;
                if (state != IDLE) state <= SHIFT;
            end else if (stap_fsm_update_dr) begin
                state             <= IDLE;
                visa_update_valid <= count_ok;
                visa_len_err      <= !count_ok;
            end
        end
    end
endmodule
